// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared constants for the RV32 data memory: funct3 access codes,
//            lane geometry and the default depth.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int c_lane_count          = 4;
    localparam int c_lane_mask_w         = c_lane_count;
    localparam int c_default_depth_words = 256;

endpackage
`default_nettype wire

// File: rtl/dmem_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : dmem_load_ext
// Brief    : Combinational byte/halfword lane select with sign or zero
//            extension, steered by the RV32 load funct3.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Halfword lane comes from addr[1] only; addr[0] is handled by the top.
    assign w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = 32'h0000_0000;
        case (i_ctrl)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_data = i_word;
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32_dmem.sv
`default_nettype none
// ============================================================================
// Module   : rv32_dmem
// Brief    : Byte-addressable RV32 data memory, combinational load path with
//            extension, byte/half/word stores on the rising clock edge.
//            Optional macro DMEM_MISALIGN_CHECK_EN adds the misalign output
//            and suppresses misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_dmem
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = c_default_depth_words
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    input  logic [2:0]  ctrl,
    input  logic        w_en,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic [31:0] outdata
);

    localparam int c_idx_w = $clog2(DEPTH_WORDS);

    logic [31:0]              r_mem [DEPTH_WORDS];
    logic [c_idx_w-1:0]       w_idx;
    logic [c_lane_mask_w-1:0] w_lane_mask;
    logic [c_lane_mask_w-1:0] w_lane_we;
    logic [31:0]              w_store_data;
    logic [31:0]              w_load_data;
    logic                     w_misalign;
    logic                     w_unused_addr;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign w_idx         = addr[c_idx_w+1:2];
    assign w_unused_addr = &{1'b0, addr[31:c_idx_w+2]};

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        case (ctrl)
            F3_H, F3_HU: w_misalign = addr[0];
            F3_W:        w_misalign = (addr[1:0] != 2'b00);
            default:     w_misalign = 1'b0;
        endcase
    end
    assign misalign = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // Replicate the store data across lanes so each lane enable can pick
    // its byte from the same bit position it lands in.
    always_comb begin
        w_lane_mask  = '0;
        w_store_data = w_data;
        case (ctrl)
            F3_B: begin
                w_lane_mask  = 4'b0001 << addr[1:0];
                w_store_data = {4{w_data[7:0]}};
            end
            F3_H: begin
                w_lane_mask  = addr[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{w_data[15:0]}};
            end
            F3_W: begin
                w_lane_mask  = 4'b1111;
                w_store_data = w_data;
            end
            default: begin
                w_lane_mask  = '0;
                w_store_data = w_data;
            end
        endcase
    end

    assign w_lane_we = (w_en && !w_misalign) ? w_lane_mask : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else begin
            for (int l = 0; l < c_lane_count; l++) begin
                if (w_lane_we[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_store_data[8*l +: 8];
                end
            end
        end
    end

    dmem_load_ext u_load_ext (
        .i_word     (r_mem[w_idx]),
        .i_byte_off (addr[1:0]),
        .i_ctrl     (ctrl),
        .o_data     (w_load_data)
    );

    assign outdata = w_misalign ? 32'h0000_0000 : w_load_data;

endmodule
`default_nettype wire

// File: tb/tb_rv32_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_dmem
// Brief    : Directed, table-driven bench for rv32_dmem (DEPTH_WORDS = 256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_dmem;

    logic        CLK;
    logic        RST_N;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [2:0]  ctrl;
    logic        w_en;
    logic [31:0] outdata;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks;
    int n_errors;

    rv32_dmem #(.DEPTH_WORDS(256)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .addr    (addr),
        .w_data  (w_data),
        .ctrl    (ctrl),
        .w_en    (w_en),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misalign(misalign),
`endif
        .outdata (outdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        ctrl = c; addr = a; w_data = d; w_en = 1'b1;
        @(posedge CLK);
        #1;
        w_en = 1'b0;
    endtask

    task automatic load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] exp, input string name);
        w_en = 1'b0; ctrl = c; addr = a;
        #1;
        check(name, outdata, exp);
    endtask

    function automatic vec_t mk(bit wr, logic [2:0] c, logic [31:0] a, logic [31:0] d,
                                logic [31:0] e, string n);
        vec_t v;
        v.wr = wr; v.ctrl = c; v.addr = a; v.data = d; v.exp = e; v.name = n;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST_N = 1'b0; addr = '0; w_data = '0; ctrl = 3'b010; w_en = 1'b0;

        vecs.push_back(mk(1, 3'b010, 32'h10,  32'h80FF7F01, 32'h0,        "sw_10"));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h80FF7F01, "lw_10"));
        vecs.push_back(mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, "lb_13"));
        vecs.push_back(mk(0, 3'b100, 32'h13,  32'h0,        32'h00000080, "lbu_13"));
        vecs.push_back(mk(0, 3'b001, 32'h12,  32'h0,        32'hFFFF80FF, "lh_12"));
        vecs.push_back(mk(0, 3'b101, 32'h10,  32'h0,        32'h00007F01, "lhu_10"));
        vecs.push_back(mk(0, 3'b000, 32'h10,  32'h0,        32'h00000001, "lb_10"));
        vecs.push_back(mk(0, 3'b000, 32'h11,  32'h0,        32'h0000007F, "lb_11"));
        vecs.push_back(mk(0, 3'b000, 32'h12,  32'h0,        32'hFFFFFFFF, "lb_12"));
        vecs.push_back(mk(0, 3'b101, 32'h12,  32'h0,        32'h000080FF, "lhu_12"));
        vecs.push_back(mk(0, 3'b001, 32'h10,  32'h0,        32'h00007F01, "lh_10"));
        vecs.push_back(mk(0, 3'b011, 32'h10,  32'h0,        32'h00000000, "ld_011"));
        vecs.push_back(mk(0, 3'b110, 32'h10,  32'h0,        32'h00000000, "ld_110"));
        vecs.push_back(mk(0, 3'b111, 32'h10,  32'h0,        32'h00000000, "ld_111"));
        vecs.push_back(mk(1, 3'b000, 32'h11,  32'hFFFFFFAA, 32'h0,        "sb_11"));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h80FFAA01, "lw_after_sb"));
        vecs.push_back(mk(1, 3'b001, 32'h12,  32'hABCD1234, 32'h0,        "sh_12"));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h1234AA01, "lw_after_sh"));
        vecs.push_back(mk(1, 3'b011, 32'h10,  32'hDEADBEEF, 32'h0,        "st_011"));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h1234AA01, "lw_after_011"));
        vecs.push_back(mk(0, 3'b011, 32'h10,  32'h0,        32'h00000000, "ld_011_after"));
        vecs.push_back(mk(1, 3'b100, 32'h10,  32'h00000000, 32'h0,        "st_bu"));
        vecs.push_back(mk(1, 3'b101, 32'h12,  32'h00000000, 32'h0,        "st_hu"));
        vecs.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h1234AA01, "lw_after_bu_hu"));
        vecs.push_back(mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        "sw_400"));
        vecs.push_back(mk(0, 3'b010, 32'h000, 32'h0,        32'hCAFEF00D, "lw_000_wrap"));
        vecs.push_back(mk(0, 3'b010, 32'h400, 32'h0,        32'hCAFEF00D, "lw_400"));
        vecs.push_back(mk(1, 3'b010, 32'h3FC, 32'h11223344, 32'h0,        "sw_3fc"));
        vecs.push_back(mk(0, 3'b100, 32'h3FF, 32'h0,        32'h00000011, "lbu_3ff"));
        vecs.push_back(mk(0, 3'b001, 32'h3FE, 32'h0,        32'h00001122, "lh_3fe"));

        // Reset: two edges with RST_N low, then release
        @(posedge CLK); @(posedge CLK); #1;
        RST_N = 1'b1;
        load(3'b010, 32'h000, 32'h0, "rst_lw_000");
        load(3'b010, 32'h004, 32'h0, "rst_lw_004");
        load(3'b010, 32'h3FC, 32'h0, "rst_lw_3fc");
        load(3'b000, 32'h013, 32'h0, "rst_lb_013");

        foreach (vecs[i]) begin
            if (vecs[i].wr) store(vecs[i].ctrl, vecs[i].addr, vecs[i].data);
            else            load(vecs[i].ctrl, vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Read during write: old value before the edge, new value right after
        store(3'b010, 32'h20, 32'h11111111);
        @(negedge CLK);
        ctrl = 3'b010; addr = 32'h20; w_data = 32'h22222222; w_en = 1'b1;
        #1;
        check("rdw_before", outdata, 32'h11111111);
        @(posedge CLK); #1;
        w_en = 1'b0;
        check("rdw_after", outdata, 32'h22222222);

        // w_en pulse between edges must not store
        @(posedge CLK); #1;
        ctrl = 3'b010; addr = 32'h20; w_data = 32'h33333333; w_en = 1'b1;
        #2;
        w_en = 1'b0;
        @(posedge CLK); #1;
        load(3'b010, 32'h20, 32'h22222222, "glitch_wen");

`ifdef DMEM_MISALIGN_CHECK_EN
        @(negedge CLK);
        ctrl = 3'b010; addr = 32'h22; w_data = 32'h99999999; w_en = 1'b1;
        #1;
        check("ma_sw_flag", {31'b0, misalign}, 32'h1);
        check("ma_sw_out", outdata, 32'h0);
        @(posedge CLK); #1;
        w_en = 1'b0;
        load(3'b010, 32'h20, 32'h22222222, "ma_word_kept");
        load(3'b001, 32'h11, 32'h0, "ma_lh_11_out");
        check("ma_lh_11_flag", {31'b0, misalign}, 32'h1);
        load(3'b101, 32'h12, 32'h00001234, "ma_lhu_12");
        check("ma_lhu_12_flag", {31'b0, misalign}, 32'h0);
`else
        // Alignment bits ignored: word store at 0x22 lands on word 0x20
        store(3'b010, 32'h22, 32'h99999999);
        load(3'b010, 32'h20, 32'h99999999, "unal_sw_22");
        load(3'b001, 32'h11, 32'hFFFFAA01, "unal_lh_11");
        load(3'b010, 32'h13, 32'h1234AA01, "unal_lw_13");
`endif

        // Reset beats a simultaneous store
        @(negedge CLK);
        RST_N = 1'b0; ctrl = 3'b010; addr = 32'h10; w_data = 32'h55555555; w_en = 1'b1;
        @(posedge CLK); #1;
        w_en = 1'b0; RST_N = 1'b1;
        load(3'b010, 32'h10, 32'h0, "rst_vs_store");
        load(3'b010, 32'h00, 32'h0, "rst_clr_000");
        load(3'b000, 32'h3FF, 32'h0, "rst_clr_3ff");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
